// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the mainMem read port from the PC, tracks read latency,
// and buffers returned words with their PCs in a small FIFO for decode.
module fetch_unit #(
  parameter logic [0:31] START_ADDRESS = 32'h80020000,
  parameter int          READ_LATENCY  = 2,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_data_in,
  input  logic [0:31] mem_data_out,
  output logic [0:1]  mem_acc_size,
  output logic        mem_wren,
  input  logic        mem_busy,
  output logic        mem_enable,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  output logic        insn_valid,
  output logic [0:31] insn,
  output logic [0:31] insn_pc,
  input  logic        insn_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_mem_enable;
  logic [0:31] r_pc;
  logic        r_epoch;

  // Latency pipe: slot 0 is the newest read, slot READ_LATENCY-1 returns this edge.
  logic        r_pv  [READ_LATENCY];
  logic [0:31] r_ppc [READ_LATENCY];
  logic        r_pep [READ_LATENCY];
  logic        r_pfl [READ_LATENCY];

  logic [0:31]   r_fifo_insn [FIFO_DEPTH];
  logic [0:31]   r_fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [SW-1:0] w_inflight;
  logic [SW-1:0] w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  // Low two bits of the redirect target are always forced to zero.
  assign w_unused = &{1'b0, redirect_pc[30:31]};

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_pv[i]);
    end
  end

  assign w_occupancy = w_inflight + SW'(r_count);

  // A read is only issued when a FIFO slot is guaranteed for its return.
  assign w_issue = (r_state == S_RUN) && !mem_busy && !redirect_valid &&
                   (w_occupancy < SW'(FIFO_DEPTH));

  assign w_push = r_pv[READ_LATENCY-1] && !r_pfl[READ_LATENCY-1] &&
                  (r_pep[READ_LATENCY-1] == r_epoch);
  assign w_pop  = (r_count != '0) && insn_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_mem_enable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state      <= S_RUN;
          r_mem_enable <= 1'b1;
        end
        S_RUN: begin
          r_state      <= S_RUN;
          r_mem_enable <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_enable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= START_ADDRESS;
      r_epoch <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[0:29], 2'b00};
      r_epoch <= ~r_epoch;
    end else if (w_issue) begin
      r_pc    <= r_pc + 32'd4;
    end
  end

  // Entries already in flight at a redirect are marked so that an even number
  // of epoch toggles cannot make them look current again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i]  <= 1'b0;
        r_ppc[i] <= '0;
        r_pep[i] <= 1'b0;
        r_pfl[i] <= 1'b0;
      end
    end else begin
      r_pv[0]  <= w_issue;
      r_ppc[0] <= r_pc;
      r_pep[0] <= r_epoch;
      r_pfl[0] <= 1'b0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_ppc[i] <= r_ppc[i-1];
        r_pep[i] <= r_pep[i-1];
        r_pfl[i] <= r_pfl[i-1] | redirect_valid;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_insn[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_insn[r_wr_ptr] <= mem_data_out;
        r_fifo_pc[r_wr_ptr]   <= r_ppc[READ_LATENCY-1];
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(!redirect_valid && w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

  assign mem_addr     = r_pc;
  assign mem_data_in  = '0;
  assign mem_acc_size = 2'b00;
  assign mem_wren     = 1'b0;
  assign mem_enable   = r_mem_enable;

  assign insn_valid = (r_count != '0);
  assign insn       = insn_valid ? r_fifo_insn[r_rd_ptr] : '0;
  assign insn_pc    = insn_valid ? r_fifo_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-2 memory model, directed scenarios, then random
// ready/busy/redirect traffic checked against an in-order fetch-stream scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [0:31] mem_addr;
  logic [0:31] mem_data_in;
  logic [0:31] mem_data_out;
  logic [0:1]  mem_acc_size;
  logic        mem_wren;
  logic        mem_busy = 1'b0;
  logic        mem_enable;
  logic        redirect_valid = 1'b0;
  logic [0:31] redirect_pc = '0;
  logic        insn_valid;
  logic [0:31] insn;
  logic [0:31] insn_pc;
  logic        insn_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] next_pc = START;
  logic [31:0] mem_a1, mem_a2;

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_acc_size   (mem_acc_size),
    .mem_wren       (mem_wren),
    .mem_busy       (mem_busy),
    .mem_enable     (mem_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0000000 + ((a - START) >> 2);
  endfunction

  // Memory: data for the address sampled at edge k is on the bus at edge k+2.
  always @(posedge clock) begin
    mem_a1 <= mem_addr;
    mem_a2 <= mem_a1;
  end
  assign mem_data_out = mem_word(mem_a2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: the decode side must see the sequential fetch stream starting at
  // START (after reset) or at the latest redirect target, with no gaps or repeats.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      next_pc = START;
    end else begin
      check("acc_size", 64'(mem_acc_size), 64'd0);
      check("wren", 64'(mem_wren), 64'd0);
      check("data_in", 64'(mem_data_in), 64'd0);
      if (redirect_valid) begin
        exp_q.delete();
        next_pc = redirect_pc & 32'hFFFFFFFC;
      end else if (insn_valid && insn_ready) begin
        logic [63:0] e;
        while (exp_q.size() < 4) begin
          exp_q.push_back({next_pc, mem_word(next_pc)});
          next_pc = next_pc + 32'd4;
        end
        e = exp_q.pop_front();
        check("pop_pc", 64'(insn_pc), 64'(e[63:32]));
        check("pop_insn", 64'(insn), 64'(e[31:0]));
        n_pops++;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    reset_n = 1'b0;
    mem_busy = 1'b0;
    redirect_valid = 1'b0;
    insn_ready = rdy;
    repeat (3) tick();
    check("rst_enable", 64'(mem_enable), 64'd0);
    check("rst_valid", 64'(insn_valid), 64'd0);
    check("rst_insn", 64'(insn), 64'd0);
    check("rst_insn_pc", 64'(insn_pc), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'(START));
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [31:0] a0;
    #1 reset_n = 1'b0;

    // Startup latency and full-throughput streaming.
    do_reset(1'b1);
    tick();
    check("t1_enable", 64'(mem_enable), 64'd1);
    check("t1_valid_e0", 64'(insn_valid), 64'd0);
    tick();
    check("t1_valid_e1", 64'(insn_valid), 64'd0);
    tick();
    check("t1_valid_e2", 64'(insn_valid), 64'd0);
    tick();
    check("t1_valid_e3", 64'(insn_valid), 64'd1);
    check("t1_pc_e3", 64'(insn_pc), 64'(START));
    check("t1_insn_e3", 64'(insn), 64'h00000000A0000000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t1_stream_valid", 64'(insn_valid), 64'd1);
      check("t1_stream_pc", 64'(insn_pc), 64'(START + 32'(4 * i)));
    end

    // Decode stalled: exactly four words get buffered.
    do_reset(1'b0);
    repeat (10) tick();
    check("t2_addr_hold", 64'(mem_addr), 64'(START + 32'h10));
    check("t2_valid", 64'(insn_valid), 64'd1);
    check("t2_insn_hold", 64'(insn), 64'h00000000A0000000);
    check("t2_pc_hold", 64'(insn_pc), 64'(START));
    mem_busy = 1'b1;
    insn_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (insn_valid) cnt++;
      tick();
    end
    check("t2_buffered", 64'(cnt), 64'd4);
    check("t2_empty", 64'(insn_valid), 64'd0);
    mem_busy = 1'b0;
    tick();
    check("t2_resume_addr", 64'(mem_addr), 64'(START + 32'h14));
    repeat (6) tick();

    // Redirect with reads in flight.
    redirect_valid = 1'b1;
    redirect_pc = 32'h80020103;
    tick();
    redirect_valid = 1'b0;
    check("t3_addr", 64'(mem_addr), 64'h80020100);
    check("t3_flushed", 64'(insn_valid), 64'd0);
    tick();
    check("t3_next_issue", 64'(mem_addr), 64'h80020104);
    check("t3_stale_1", 64'(insn_valid), 64'd0);
    tick();
    check("t3_stale_2", 64'(insn_valid), 64'd0);
    tick();
    check("t3_first_valid", 64'(insn_valid), 64'd1);
    check("t3_first_pc", 64'(insn_pc), 64'h80020100);
    repeat (4) tick();

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h80020040;
    tick();
    redirect_pc = 32'h80020080;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t4_gap_1", 64'(insn_valid), 64'd0);
    tick();
    check("t4_gap_2", 64'(insn_valid), 64'd0);
    tick();
    check("t4_valid", 64'(insn_valid), 64'd1);
    check("t4_pc", 64'(insn_pc), 64'h80020080);
    repeat (5) tick();

    // Memory busy freezes the PC while the FIFO drains.
    a0 = mem_addr;
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_addr_frozen", 64'(mem_addr), 64'(a0));
    end
    check("t5_drained", 64'(insn_valid), 64'd0);
    mem_busy = 1'b0;
    tick();
    check("t5_resume", 64'(mem_addr), 64'(a0 + 32'd4));
    repeat (5) tick();

    // Asynchronous reset mid-stream, restart, then PC wrap via redirect.
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(insn_valid), 64'd0);
    check("t6_async_insn", 64'(insn), 64'd0);
    check("t6_async_pc", 64'(insn_pc), 64'd0);
    check("t6_async_en", 64'(mem_enable), 64'd0);
    check("t6_async_addr", 64'(mem_addr), 64'(START));
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("t6_restart_valid", 64'(insn_valid), 64'd1);
    check("t6_restart_pc", 64'(insn_pc), 64'(START));
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFFFFFF;
    tick();
    redirect_valid = 1'b0;
    check("t6_wrap_addr", 64'(mem_addr), 64'hFFFFFFFC);
    tick();
    check("t6_wrap_zero", 64'(mem_addr), 64'd0);
    repeat (2) tick();
    check("t6_wrap_pc_top", 64'(insn_pc), 64'hFFFFFFFC);
    tick();
    check("t6_wrap_pc_zero", 64'(insn_pc), 64'd0);
    repeat (3) tick();

    // Random ready / busy / redirect traffic.
    cnt = n_pops;
    for (int i = 0; i < 2000; i++) begin
      insn_ready = ($urandom_range(0, 9) < 7);
      mem_busy = ($urandom_range(0, 9) < 2);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = START + 32'($urandom_range(0, 1023));
      tick();
    end
    redirect_valid = 1'b0;
    mem_busy = 1'b0;
    insn_ready = 1'b1;
    repeat (10) tick();
    check("rand_progress", 64'((n_pops - cnt) >= 200), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
